// File: rtl/roic_scan_pkg.sv
// Shared types and default sizes for the ROIC power-up scan sequencer.
package roic_scan_pkg;

  localparam int CNT_W_DEF        = 16;
  localparam int FRM_W_DEF        = 8;
  localparam int MIN_LINE_LEN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BACK_BIAS = 2'd1,
    FLUSH     = 2'd2,
    DONE      = 2'd3
  } scan_state_e;

endpackage

// File: rtl/roic_scan_line_cnt.sv
// Column/row counter pair for one scan; strobes are decoded from the registered counts.
module roic_scan_line_cnt
  import roic_scan_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] line_len,
  input  logic [CNT_W-1:0] rows,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             col_end,
  output logic             frame_end
);

  assign col_end   = en && (col_cnt == line_len - CNT_W'(1));
  assign frame_end = col_end && (row_cnt == rows - CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (en) begin
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= frame_end ? '0 : row_cnt + CNT_W'(1);
      end else begin
        col_cnt <= col_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/roic_scan_seq.sv
// Power-up sequencer: back-bias scan, N flush frames, then a one-cycle done pulse.
module roic_scan_seq
  import roic_scan_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FRM_W        = FRM_W_DEF,
  parameter int MIN_LINE_LEN = MIN_LINE_LEN_DEF
) (
  input  logic             fsm_clk,
  input  logic             fsm_drv_rst,
  input  logic             seq_start,
  input  logic             seq_abort,
  input  logic [CNT_W-1:0] cfg_line_len,
  input  logic [CNT_W-1:0] cfg_bb_rows,
  input  logic [CNT_W-1:0] cfg_flush_rows,
  input  logic [FRM_W-1:0] cfg_flush_frames,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] col_cnt,
  output logic             col_end,
  output logic             frame_end,
  output logic             fsm_back_bias_index,
  output logic             fsm_flush_index,
  output logic [FRM_W-1:0] flush_frame_cnt,
  output logic             busy,
  output logic             seq_done
);

  scan_state_e      state, state_next;
  logic [CNT_W-1:0] line_len_q, bb_rows_q, flush_rows_q;
  logic [FRM_W-1:0] flush_frames_q;
  logic [CNT_W-1:0] line_len_eff, rows_sel;
  logic             start_ok, flush_en_cfg, flush_en_q, last_frame;
  logic             scan_active, next_scan;

  assign start_ok     = (state == IDLE) && seq_start && !seq_abort;
  assign line_len_eff = (cfg_line_len < CNT_W'(MIN_LINE_LEN)) ? CNT_W'(MIN_LINE_LEN) : cfg_line_len;
  assign flush_en_cfg = (cfg_flush_rows != '0) && (cfg_flush_frames != '0);
  assign flush_en_q   = (flush_rows_q != '0) && (flush_frames_q != '0);
  assign last_frame   = (flush_frame_cnt == flush_frames_q - FRM_W'(1));
  assign scan_active  = (state == BACK_BIAS) || (state == FLUSH);
  assign next_scan    = (state_next == BACK_BIAS) || (state_next == FLUSH);
  assign rows_sel     = (state == BACK_BIAS) ? bb_rows_q : flush_rows_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          if (cfg_bb_rows != '0) state_next = BACK_BIAS;
          else if (flush_en_cfg) state_next = FLUSH;
          else                   state_next = DONE;
        end
      end
      BACK_BIAS: begin
        if (seq_abort)      state_next = IDLE;
        else if (frame_end) state_next = flush_en_q ? FLUSH : DONE;
      end
      FLUSH: begin
        if (seq_abort)                    state_next = IDLE;
        else if (frame_end && last_frame) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge fsm_clk or negedge fsm_drv_rst) begin
    if (!fsm_drv_rst) state <= IDLE;
    else              state <= state_next;
  end

  // Config is captured only on an accepted start; mid-run cfg edits are invisible.
  always_ff @(posedge fsm_clk or negedge fsm_drv_rst) begin
    if (!fsm_drv_rst) begin
      line_len_q     <= CNT_W'(MIN_LINE_LEN);
      bb_rows_q      <= '0;
      flush_rows_q   <= '0;
      flush_frames_q <= '0;
    end else if (start_ok) begin
      line_len_q     <= line_len_eff;
      bb_rows_q      <= cfg_bb_rows;
      flush_rows_q   <= cfg_flush_rows;
      flush_frames_q <= cfg_flush_frames;
    end
  end

  always_ff @(posedge fsm_clk or negedge fsm_drv_rst) begin
    if (!fsm_drv_rst)                     flush_frame_cnt <= '0;
    else if (state_next != FLUSH)         flush_frame_cnt <= '0;
    else if (state == FLUSH && frame_end) flush_frame_cnt <= flush_frame_cnt + FRM_W'(1);
  end

  // Counters sit at zero outside scans, so every scan entry starts at row 0 / col 0.
  roic_scan_line_cnt #(.CNT_W(CNT_W)) u_line_cnt (
    .clk      (fsm_clk),
    .rst_n    (fsm_drv_rst),
    .clear    (!next_scan),
    .en       (scan_active),
    .line_len (line_len_q),
    .rows     (rows_sel),
    .col_cnt  (col_cnt),
    .row_cnt  (row_cnt),
    .col_end  (col_end),
    .frame_end(frame_end)
  );

  assign fsm_back_bias_index = (state == BACK_BIAS);
  assign fsm_flush_index     = (state == FLUSH);
  assign busy                = (state != IDLE);
  assign seq_done            = (state == DONE);

endmodule

// File: tb/tb_roic_scan_seq.sv
// Scoreboard bench: per-cycle expected outputs are enumerated at start and popped each cycle.
module tb_roic_scan_seq;

  logic        fsm_clk = 1'b0;
  logic        fsm_drv_rst = 1'b0;
  logic        seq_start = 1'b0;
  logic        seq_abort = 1'b0;
  logic [15:0] cfg_line_len = '0;
  logic [15:0] cfg_bb_rows = '0;
  logic [15:0] cfg_flush_rows = '0;
  logic [7:0]  cfg_flush_frames = '0;
  logic [15:0] row_cnt, col_cnt;
  logic        col_end, frame_end, fsm_back_bias_index, fsm_flush_index, busy, seq_done;
  logic [7:0]  flush_frame_cnt;

  typedef struct packed {
    logic        busy;
    logic        bb;
    logic        fl;
    logic        done;
    logic        ce;
    logic        fe;
    logic [15:0] row;
    logic [15:0] col;
    logic [7:0]  ffc;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  roic_scan_seq dut (
    .fsm_clk            (fsm_clk),
    .fsm_drv_rst        (fsm_drv_rst),
    .seq_start          (seq_start),
    .seq_abort          (seq_abort),
    .cfg_line_len       (cfg_line_len),
    .cfg_bb_rows        (cfg_bb_rows),
    .cfg_flush_rows     (cfg_flush_rows),
    .cfg_flush_frames   (cfg_flush_frames),
    .row_cnt            (row_cnt),
    .col_cnt            (col_cnt),
    .col_end            (col_end),
    .frame_end          (frame_end),
    .fsm_back_bias_index(fsm_back_bias_index),
    .fsm_flush_index    (fsm_flush_index),
    .flush_frame_cnt    (flush_frame_cnt),
    .busy               (busy),
    .seq_done           (seq_done)
  );

  always #20 fsm_clk = ~fsm_clk;

  function automatic obs_t observe();
    obs_t o;
    o = {busy, fsm_back_bias_index, fsm_flush_index, seq_done, col_end, frame_end,
         row_cnt, col_cnt, flush_frame_cnt};
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    return o;
  endfunction

  // Enumerate the whole expected sequence from the raw config, cycle 1 onward.
  task automatic push_expected(input int line, input int bb, input int fr, input int ff);
    int   l;
    obs_t o;
    l = (line < 2) ? 2 : line;
    for (int r = 0; r < bb; r++)
      for (int c = 0; c < l; c++) begin
        o = '0;
        o.busy = 1'b1; o.bb = 1'b1;
        o.ce = (c == l - 1); o.fe = (c == l - 1) && (r == bb - 1);
        o.row = 16'(r); o.col = 16'(c);
        exp_q.push_back(o);
      end
    if (fr != 0 && ff != 0)
      for (int f = 0; f < ff; f++)
        for (int r = 0; r < fr; r++)
          for (int c = 0; c < l; c++) begin
            o = '0;
            o.busy = 1'b1; o.fl = 1'b1;
            o.ce = (c == l - 1); o.fe = (c == l - 1) && (r == fr - 1);
            o.row = 16'(r); o.col = 16'(c); o.ffc = 8'(f);
            exp_q.push_back(o);
          end
    o = '0;
    o.busy = 1'b1; o.done = 1'b1;
    exp_q.push_back(o);
    exp_q.push_back(idle_obs());
  endtask

  // Called at a negedge; the start is sampled by the following posedge (cycle 0).
  task automatic run_seq(input int line, input int bb, input int fr, input int ff,
                         input bit disturb, input bit start_in_done, input int abort_at);
    int   n;
    obs_t e;
    exp_q.delete();
    push_expected(line, bb, fr, ff);
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(idle_obs());
    end
    cfg_line_len = 16'(line); cfg_bb_rows = 16'(bb);
    cfg_flush_rows = 16'(fr); cfg_flush_frames = 8'(ff);
    seq_start = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge fsm_clk);
      seq_start = 1'b0;
      seq_abort = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("l%0d_b%0d_f%0dx%0d_cyc%0d", line, bb, fr, ff, i + 1), observe(), e);
      if (disturb && i == 1) begin
        seq_start = 1'b1;
        cfg_line_len = 16'd1; cfg_bb_rows = 16'hffff;
        cfg_flush_rows = 16'd9; cfg_flush_frames = 8'd200;
      end
      if (i == abort_at) seq_abort = 1'b1;
      if (start_in_done && e.done) seq_start = 1'b1;
    end
  endtask

  initial begin
    bit found;
    repeat (2) @(negedge fsm_clk);
    exp_q.push_back(idle_obs());
    check("reset_state", observe(), exp_q.pop_front());
    fsm_drv_rst = 1'b1;
    @(negedge fsm_clk);

    run_seq(4, 3, 5, 0, 1'b0, 1'b0, -1);
    run_seq(3, 2, 2, 3, 1'b0, 1'b1, -1);
    run_seq(0, 2, 0, 0, 1'b0, 1'b0, -1);
    run_seq(0, 0, 0, 0, 1'b0, 1'b0, -1);
    run_seq(7, 0, 0, 4, 1'b0, 1'b0, -1);
    run_seq(5, 0, 3, 2, 1'b0, 1'b0, -1);
    run_seq(2, 3, 1, 2, 1'b1, 1'b0, -1);
    run_seq(3, 2, 2, 3, 1'b0, 1'b0, 11);

    // Abort together with start in IDLE: the start must be dropped.
    seq_start = 1'b1; seq_abort = 1'b1;
    cfg_bb_rows = 16'd2; cfg_line_len = 16'd3;
    exp_q.push_back(idle_obs());
    exp_q.push_back(idle_obs());
    for (int i = 0; i < 2; i++) begin
      @(negedge fsm_clk);
      seq_start = 1'b0; seq_abort = 1'b0;
      check($sformatf("abort_start_idle_%0d", i), observe(), exp_q.pop_front());
    end

    // Asynchronous reset in the middle of a back-bias scan at row 3.
    cfg_line_len = 16'd4; cfg_bb_rows = 16'd5; cfg_flush_rows = 16'd0; cfg_flush_frames = 8'd0;
    seq_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge fsm_clk);
      seq_start = 1'b0;
      if (fsm_back_bias_index && row_cnt == 16'd3) found = 1'b1;
    end
    if (!found) check("rst_wait_row3", idle_obs(), obs_t'(1));
    #2 fsm_drv_rst = 1'b0;
    exp_q.push_back(idle_obs());
    #1 check("rst_async_clear", observe(), exp_q.pop_front());
    @(negedge fsm_clk);
    exp_q.push_back(idle_obs());
    check("rst_held", observe(), exp_q.pop_front());
    fsm_drv_rst = 1'b1;
    repeat (2) begin
      @(negedge fsm_clk);
      exp_q.push_back(idle_obs());
      check("rst_release_idle", observe(), exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
